mips_multicycle_ctrl: RTL and testbench
=======================================

# mips_multicycle_ctrl

Main control FSM for the multicycle MIPS datapath: sequences each instruction through fetch, decode, execute, memory and writeback states. It drives every datapath enable and mux select, including the 2-bit `alu_op` consumed directly by the downstream `alu_control` decoder. It also keeps a retired-instruction counter for debug and performance visibility.

## Interface
Parameters:
- `CNT_W`, default 32: width of the retired-instruction counter.

Ports:
- `clk` input 1: single clock; all state changes on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `opcode` input 6: instr[31:26] from the instruction register.
- `zero` input 1: ALU zero flag.
- `ir_write` output 1: instruction register load.
- `mem_write` output 1: data memory write.
- `reg_write` output 1: register file write.
- `iord` output 1: memory address select (0 = PC, 1 = ALUOut).
- `mem_to_reg` output 1: writeback data select (1 = memory data).
- `reg_dst` output 1: destination register select (1 = rd).
- `alu_src_a` output 1: ALU A select (0 = PC, 1 = register A).
- `alu_src_b` output 2: ALU B select (00 = B, 01 = 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2).
- `alu_op` output 2: to `alu_control` (00 = add, 01 = sub, 10 = use funct).
- `pc_src` output 2: next-PC select (00 = ALU result, 01 = ALUOut, 10 = jump target).
- `pc_en` output 1: PC load enable.
- `state_o` output 4: current state, for debug.
- `retired` output CNT_W: count of completed instructions.

## Operation
- Moore FSM with a 4-bit state register. Encodings: IDLE=0, FETCH=1, DECODE=2, MEMADR=3, MEMRD=4, MEMWB=5, MEMWR=6, RTYPEEX=7, RTYPEWB=8, BEQEX=9, ADDIEX=10, ADDIWB=11, JEX=12, BNEEX=13.
- Transitions:
  - IDLE→FETCH; FETCH→DECODE.
  - DECODE dispatches on opcode: 100011/101011→MEMADR; 000000→RTYPEEX; 000100→BEQEX; 001000→ADDIEX; 000010→JEX; any other opcode→FETCH.
  - MEMADR→MEMRD (lw) or MEMWR (sw).
  - MEMRD→MEMWB; RTYPEEX→RTYPEWB; ADDIEX→ADDIWB.
  - MEMWB, MEMWR, RTYPEWB, ADDIWB, BEQEX, JEX and BNEEX all →FETCH.
  - Illegal or unused encodings→FETCH.
- Outputs per state. Any output not listed is 0.
  - FETCH: ir_write=1, pc_write=1, alu_src_b=01.
  - DECODE: alu_src_b=11.
  - MEMADR: alu_src_a=1, alu_src_b=10.
  - MEMRD: iord=1.
  - MEMWB: mem_to_reg=1, reg_write=1.
  - MEMWR: iord=1, mem_write=1.
  - RTYPEEX: alu_src_a=1, alu_op=10.
  - RTYPEWB: reg_dst=1, reg_write=1.
  - BEQEX: alu_src_a=1, alu_op=01, pc_src=01, branch=1.
  - ADDIEX: alu_src_a=1, alu_src_b=10.
  - ADDIWB: reg_write=1.
  - JEX: pc_src=10, pc_write=1.
  - IDLE: all outputs 0.
- `pc_en = pc_write | (branch & zero) [| (branch_ne & ~zero)]`. This is combinational, so `zero` is used in the same cycle.
- `retired` increments by 1, wrapping modulo 2^CNT_W, on every transition from a terminal state (MEMWB, MEMWR, RTYPEWB, ADDIWB, BEQEX, JEX, BNEEX) into FETCH.
  - An illegal opcode's DECODE→FETCH does not count.

## Timing
- Reset (rst_n low, asynchronous): state=IDLE, retired=0, all outputs 0.
- First FETCH occurs in the first cycle after rst_n deasserts.
- Cycles per instruction, counted from FETCH to the next FETCH:
  - lw 5; sw 4; R-type 4; addi 4; beq 3; j 3; bne 3.
  - Illegal opcode: 2.
- Reset mid-instruction aborts immediately. No write enable is asserted in the reset cycle or in IDLE.
- `opcode` is sampled only in DECODE and MEMADR. It must be stable from the end of FETCH.

## Configuration
- `MIPS_CTRL_BNE_EN` defined:
  - Opcode 000101 dispatches DECODE→BNEEX.
  - BNEEX outputs: alu_src_a=1, alu_op=01, pc_src=01, internal branch_ne=1.
  - pc_en includes the `branch_ne & ~zero` term.
- Macro undefined:
  - 000101 is treated as illegal and goes DECODE→FETCH.
  - BNEEX is unreachable and encoding 13 decodes as illegal.
  - branch_ne is tied to 0.

## Structure
- Shared package/header `mips_pkg` holds:
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ADDI, OP_J);
  - state encodings;
  - alu_op encodings (ALUOP_ADD=00, ALUOP_SUB=01, ALUOP_FUNCT=10);
  - alu_src_b and pc_src select constants.
- The state register, next-state logic and counter live in `mips_multicycle_ctrl`.
- The per-state output lookup is one sub-module, `mips_ctrl_out_dec`: combinational, state→output vector.

## Test plan
- Reset, then release: state_o goes 0→1; in FETCH ir_write=1, pc_en=1, alu_src_b=01; retired=0.
- R-type (000000): DECODE→RTYPEEX with alu_op=10, then RTYPEWB with reg_write=1, reg_dst=1; retired 0→1 after 4 cycles.
- lw (100011): 5-cycle path. MEMRD has iord=1; MEMWB has mem_to_reg=1, reg_write=1. Then sw (101011): MEMWR has mem_write=1; retired=2.
- beq with zero=1: BEQEX has pc_en=1, pc_src=01, alu_op=01. With zero=0: pc_en=0. Both take 3 cycles.
- Opcode 111111: FETCH→DECODE→FETCH, no write enable asserted, retired unchanged. Assert rst_n low during MEMRD: immediately state=IDLE, retired=0.
- Opcode 000101 with zero=0: macro defined → BNEEX with pc_en=1; macro undefined → DECODE→FETCH with pc_en=0.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared constants for the multicycle MIPS control path: opcodes, FSM state
// encodings, ALU/mux select codes and the control-word layout.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_REG     = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_FETCH   = 4'd1,
        S_DECODE  = 4'd2,
        S_MEMADR  = 4'd3,
        S_MEMRD   = 4'd4,
        S_MEMWB   = 4'd5,
        S_MEMWR   = 4'd6,
        S_RTYPEEX = 4'd7,
        S_RTYPEWB = 4'd8,
        S_BEQEX   = 4'd9,
        S_ADDIEX  = 4'd10,
        S_ADDIWB  = 4'd11,
        S_JEX     = 4'd12,
        S_BNEEX   = 4'd13
    } state_t;

    typedef struct packed {
        logic       ir_write;
        logic       mem_write;
        logic       reg_write;
        logic       iord;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_src;
        logic       pc_write;
        logic       branch;
        logic       branch_ne;
    } ctrl_t;

    // Last state of an instruction; leaving it retires that instruction.
    function automatic logic is_terminal(input state_t s);
        case (s)
            S_MEMWB, S_MEMWR, S_RTYPEWB, S_ADDIWB, S_BEQEX, S_JEX: is_terminal = 1'b1;
`ifdef MIPS_CTRL_BNE_EN
            S_BNEEX: is_terminal = 1'b1;
`endif
            default: is_terminal = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mips_multicycle_ctrl_if.sv
// Controller <-> datapath bundle: instruction fields and flags in, control
// strobes, mux selects and debug visibility out.
interface mips_multicycle_ctrl_if #(parameter int CNT_W = 32);
    logic [5:0]       opcode;
    logic             zero;
    logic             ir_write;
    logic             mem_write;
    logic             reg_write;
    logic             iord;
    logic             mem_to_reg;
    logic             reg_dst;
    logic             alu_src_a;
    logic [1:0]       alu_src_b;
    logic [1:0]       alu_op;
    logic [1:0]       pc_src;
    logic             pc_en;
    logic [3:0]       state_o;
    logic [CNT_W-1:0] retired;

    modport master (
        input  opcode, zero,
        output ir_write, mem_write, reg_write, iord, mem_to_reg, reg_dst,
               alu_src_a, alu_src_b, alu_op, pc_src, pc_en, state_o, retired
    );

    modport slave (
        output opcode, zero,
        input  ir_write, mem_write, reg_write, iord, mem_to_reg, reg_dst,
               alu_src_a, alu_src_b, alu_op, pc_src, pc_en, state_o, retired
    );
endinterface

// File: rtl/mips_ctrl_out_dec.sv
// Moore output lookup: maps the current FSM state onto the full control word.
// Optional BNE support is controlled by the MIPS_CTRL_BNE_EN macro.
module mips_ctrl_out_dec
    import mips_pkg::*;
(
    input  state_t state,
    output ctrl_t  ctrl
);

    // Per-state control word; unlisted fields stay zero.
    always_comb begin
        ctrl = '0;
        case (state)
            S_FETCH: begin
                ctrl.ir_write  = 1'b1;
                ctrl.pc_write  = 1'b1;
                ctrl.alu_src_b = SRCB_FOUR;
            end
            S_DECODE: ctrl.alu_src_b = SRCB_IMM_SH2;
            S_MEMADR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
            end
            S_MEMRD: ctrl.iord = 1'b1;
            S_MEMWB: begin
                ctrl.mem_to_reg = 1'b1;
                ctrl.reg_write  = 1'b1;
            end
            S_MEMWR: begin
                ctrl.iord      = 1'b1;
                ctrl.mem_write = 1'b1;
            end
            S_RTYPEEX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_op    = ALUOP_FUNCT;
            end
            S_RTYPEWB: begin
                ctrl.reg_dst   = 1'b1;
                ctrl.reg_write = 1'b1;
            end
            S_BEQEX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_op    = ALUOP_SUB;
                ctrl.pc_src    = PCSRC_ALUOUT;
                ctrl.branch    = 1'b1;
            end
            S_ADDIEX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
            end
            S_ADDIWB: ctrl.reg_write = 1'b1;
            S_JEX: begin
                ctrl.pc_src   = PCSRC_JUMP;
                ctrl.pc_write = 1'b1;
            end
`ifdef MIPS_CTRL_BNE_EN
            S_BNEEX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_op    = ALUOP_SUB;
                ctrl.pc_src    = PCSRC_ALUOUT;
                ctrl.branch_ne = 1'b1;
            end
`endif
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Main control FSM of the multicycle MIPS datapath plus retired-instruction counter.
// Defining MIPS_CTRL_BNE_EN adds the BNE instruction path.
module mips_multicycle_ctrl
    import mips_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    mips_multicycle_ctrl_if.master  bus
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state_r;
    state_t           state_next_s;
    logic [CNT_W-1:0] retired_r;
    ctrl_t            ctrl_s;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic; anything unrecognised falls back to FETCH.
    always_comb begin
        state_next_s = S_FETCH;
        case (state_r)
            S_IDLE:   state_next_s = S_FETCH;
            S_FETCH:  state_next_s = S_DECODE;
            S_DECODE: begin
                case (bus.opcode)
                    OP_LW, OP_SW: state_next_s = S_MEMADR;
                    OP_RTYPE:     state_next_s = S_RTYPEEX;
                    OP_BEQ:       state_next_s = S_BEQEX;
                    OP_ADDI:      state_next_s = S_ADDIEX;
                    OP_J:         state_next_s = S_JEX;
`ifdef MIPS_CTRL_BNE_EN
                    OP_BNE:       state_next_s = S_BNEEX;
`endif
                    default:      state_next_s = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                if (bus.opcode == OP_LW) begin
                    state_next_s = S_MEMRD;
                end else begin
                    state_next_s = S_MEMWR;
                end
            end
            S_MEMRD:   state_next_s = S_MEMWB;
            S_RTYPEEX: state_next_s = S_RTYPEWB;
            S_ADDIEX:  state_next_s = S_ADDIWB;
            default:   state_next_s = S_FETCH;
        endcase
    end

    // Retired counter: bumps only when a completed instruction hands back to FETCH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retired_r <= '0;
        end else if (is_terminal(state_r) && (state_next_s == S_FETCH)) begin
            retired_r <= retired_r + CNT_ONE;
        end else begin
            retired_r <= retired_r;
        end
    end

    mips_ctrl_out_dec u_out_dec (
        .state (state_r),
        .ctrl  (ctrl_s)
    );

    // branch_ne is forced low by the decoder when BNE support is compiled out.
    assign bus.pc_en      = ctrl_s.pc_write | (ctrl_s.branch & bus.zero)
                          | (ctrl_s.branch_ne & ~bus.zero);
    assign bus.ir_write   = ctrl_s.ir_write;
    assign bus.mem_write  = ctrl_s.mem_write;
    assign bus.reg_write  = ctrl_s.reg_write;
    assign bus.iord       = ctrl_s.iord;
    assign bus.mem_to_reg = ctrl_s.mem_to_reg;
    assign bus.reg_dst    = ctrl_s.reg_dst;
    assign bus.alu_src_a  = ctrl_s.alu_src_a;
    assign bus.alu_src_b  = ctrl_s.alu_src_b;
    assign bus.alu_op     = ctrl_s.alu_op;
    assign bus.pc_src     = ctrl_s.pc_src;
    assign bus.state_o    = state_r;
    assign bus.retired    = retired_r;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Self-checking bench for mips_multicycle_ctrl: directed instruction mix then
// randomized opcodes/zero flag against an instruction-level reference model.
module tb_mips_multicycle_ctrl;

    localparam int CNT_W = 32;

    localparam int P_IDLE = 0, P_FETCH = 1, P_DECODE = 2, P_MEMADR = 3, P_MEMRD = 4,
                   P_MEMWB = 5, P_MEMWR = 6, P_RTEX = 7, P_RTWB = 8, P_BEQ = 9,
                   P_ADDIEX = 10, P_ADDIWB = 11, P_JEX = 12, P_BNE = 13;

    typedef struct packed {
        logic [3:0]  st;
        logic        irw, mw, rw, iord, m2r, rdst, srca;
        logic [1:0]  srcb, aluop, pcsrc;
        logic        pcen;
        logic [31:0] ret;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    mips_multicycle_ctrl_if #(.CNT_W(CNT_W)) bus ();

    mips_multicycle_ctrl #(.CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    exp_t        expq[$];
    int          tests = 0;
    int          fails = 0;
    logic [31:0] model_ret = 32'd0;
    bit          pin_fetch = 1'b0;
    bit          pin_ret_en = 1'b0;
    logic [31:0] pin_ret = 32'd0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, req, $time);
        end
    endtask

    // What each step of an instruction must drive, from its role in the instruction.
    function automatic exp_t expect_of(input int p, input logic z, input logic [31:0] ret);
        exp_t e;
        e = '0;
        e.st  = p[3:0];
        e.ret = ret;
        case (p)
            P_FETCH:  begin e.irw = 1'b1; e.srcb = 2'b01; e.pcen = 1'b1; end
            P_DECODE: e.srcb = 2'b11;
            P_MEMADR: begin e.srca = 1'b1; e.srcb = 2'b10; end
            P_MEMRD:  e.iord = 1'b1;
            P_MEMWB:  begin e.m2r = 1'b1; e.rw = 1'b1; end
            P_MEMWR:  begin e.iord = 1'b1; e.mw = 1'b1; end
            P_RTEX:   begin e.srca = 1'b1; e.aluop = 2'b10; end
            P_RTWB:   begin e.rdst = 1'b1; e.rw = 1'b1; end
            P_BEQ:    begin e.srca = 1'b1; e.aluop = 2'b01; e.pcsrc = 2'b01; e.pcen = z; end
            P_ADDIEX: begin e.srca = 1'b1; e.srcb = 2'b10; end
            P_ADDIWB: e.rw = 1'b1;
            P_JEX:    begin e.pcsrc = 2'b10; e.pcen = 1'b1; end
            P_BNE:    begin e.srca = 1'b1; e.aluop = 2'b01; e.pcsrc = 2'b01; e.pcen = ~z; end
            default:  e.pcen = 1'b0;
        endcase
        return e;
    endfunction

    // Drive one instruction; zmode 0/1 forces zero, 2 randomizes it each cycle.
    // stop_after > 0 truncates the instruction after that many steps.
    task automatic run_instr(input logic [5:0] op, input int zmode, input int stop_after);
        int   ph[$];
        bit   legal;
        exp_t e;
        legal = 1'b1;
        case (op)
            6'b000000: ph = '{P_FETCH, P_DECODE, P_RTEX, P_RTWB};
            6'b100011: ph = '{P_FETCH, P_DECODE, P_MEMADR, P_MEMRD, P_MEMWB};
            6'b101011: ph = '{P_FETCH, P_DECODE, P_MEMADR, P_MEMWR};
            6'b000100: ph = '{P_FETCH, P_DECODE, P_BEQ};
            6'b001000: ph = '{P_FETCH, P_DECODE, P_ADDIEX, P_ADDIWB};
            6'b000010: ph = '{P_FETCH, P_DECODE, P_JEX};
`ifdef MIPS_CTRL_BNE_EN
            6'b000101: ph = '{P_FETCH, P_DECODE, P_BNE};
`endif
            default: begin ph = '{P_FETCH, P_DECODE}; legal = 1'b0; end
        endcase
        foreach (ph[i]) begin
            if (stop_after == 0 || i < stop_after) begin
                @(posedge clk);
                #1;
                if (i == 0) bus.opcode = op;
                bus.zero = (zmode == 2) ? 1'($urandom_range(0, 1)) : zmode[0];
                e = expect_of(ph[i], bus.zero, model_ret);
                expq.push_back(e);
                if (i == 0 && pin_fetch) begin
                    #1;
                    pin_fetch = 1'b0;
                    chk("pin_first_state", 64'(bus.state_o), 64'd1);
                    chk("pin_first_ir_write", 64'(bus.ir_write), 64'd1);
                    chk("pin_first_pc_en", 64'(bus.pc_en), 64'd1);
                    chk("pin_first_alu_src_b", 64'(bus.alu_src_b), 64'd1);
                    chk("pin_first_retired", 64'(bus.retired), 64'd0);
                end
                if (i == 0 && pin_ret_en) begin
                    pin_ret_en = 1'b0;
                    chk("pin_retired", 64'(bus.retired), 64'(pin_ret));
                end
            end
        end
        if (legal && stop_after == 0) model_ret = model_ret + 32'd1;
    endtask

    // Cycle-by-cycle comparison against the model's queued expectations.
    always @(negedge clk) begin
        exp_t e;
        if (expq.size() > 0) begin
            e = expq.pop_front();
            chk("state_o",    64'(bus.state_o),    64'(e.st));
            chk("ir_write",   64'(bus.ir_write),   64'(e.irw));
            chk("mem_write",  64'(bus.mem_write),  64'(e.mw));
            chk("reg_write",  64'(bus.reg_write),  64'(e.rw));
            chk("iord",       64'(bus.iord),       64'(e.iord));
            chk("mem_to_reg", 64'(bus.mem_to_reg), 64'(e.m2r));
            chk("reg_dst",    64'(bus.reg_dst),    64'(e.rdst));
            chk("alu_src_a",  64'(bus.alu_src_a),  64'(e.srca));
            chk("alu_src_b",  64'(bus.alu_src_b),  64'(e.srcb));
            chk("alu_op",     64'(bus.alu_op),     64'(e.aluop));
            chk("pc_src",     64'(bus.pc_src),     64'(e.pcsrc));
            chk("pc_en",      64'(bus.pc_en),      64'(e.pcen));
            chk("retired",    64'(bus.retired),    64'(e.ret));
        end
    end

    task automatic check_reset_quiet(input string tag);
        chk({tag, "_state"},     64'(bus.state_o),   64'd0);
        chk({tag, "_retired"},   64'(bus.retired),   64'd0);
        chk({tag, "_ir_write"},  64'(bus.ir_write),  64'd0);
        chk({tag, "_mem_write"}, 64'(bus.mem_write), 64'd0);
        chk({tag, "_reg_write"}, 64'(bus.reg_write), 64'd0);
        chk({tag, "_pc_en"},     64'(bus.pc_en),     64'd0);
    endtask

    logic [5:0] op_tab [8];

    initial begin
        logic [5:0] op;
        op_tab = '{6'b000000, 6'b100011, 6'b101011, 6'b000100,
                   6'b000101, 6'b001000, 6'b000010, 6'b111111};
        rst_n      = 1'b0;
        bus.opcode = 6'd0;
        bus.zero   = 1'b1;
        #3;
        check_reset_quiet("reset");
        @(negedge clk);
        rst_n     = 1'b1;
        pin_fetch = 1'b1;

        // Directed: R-type, lw, sw, beq taken/not taken, illegal, bne with zero=0.
        run_instr(6'b000000, 2, 0);
        run_instr(6'b100011, 2, 0);
        run_instr(6'b101011, 2, 0);
        run_instr(6'b000100, 1, 0);
        run_instr(6'b000100, 0, 0);
        run_instr(6'b111111, 2, 0);
        run_instr(6'b000101, 0, 0);
        run_instr(6'b001000, 2, 0);
        run_instr(6'b000010, 2, 0);
        pin_ret_en = 1'b1;
`ifdef MIPS_CTRL_BNE_EN
        pin_ret = 32'd8;
`else
        pin_ret = 32'd7;
`endif
        run_instr(6'b000000, 2, 0);

        // Abort a lw in MEMRD with an asynchronous reset.
        run_instr(6'b100011, 2, 4);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_quiet("abort");
        model_ret = 32'd0;
        @(posedge clk);
        #1;
        check_reset_quiet("held");
        @(negedge clk);
        rst_n = 1'b1;

        for (int n = 0; n < 400; n++) begin
            op = op_tab[$urandom_range(0, 7)];
            if ($urandom_range(0, 9) == 0) op = 6'($urandom);
            run_instr(op, 2, 0);
        end
        pin_ret_en = 1'b1;
        pin_ret    = model_ret;
        run_instr(6'b000010, 2, 0);

        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
